// File: rtl/square_wave_period_detector.sv
// Measures the rise-to-rise period of an asynchronous square wave and flags tone lock / signal loss.
// Optional build macro GLITCH_FILTER_EN inserts a stability filter ahead of edge detection.
module square_wave_period_detector #(
  parameter int unsigned CLK_FREQ      = 25_000_000,
  parameter int unsigned WAVE_FREQ     = 1_000,
  parameter int unsigned TOL_COUNT     = 250,
  parameter int unsigned LOCK_CYCLES   = 4,
  parameter int unsigned TIMEOUT_COUNT = 2 * (CLK_FREQ / WAVE_FREQ),
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wave_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             tone_lock,
  output logic             no_signal,
  output logic             led
);

  localparam int unsigned EXP_PERIOD = CLK_FREQ / WAVE_FREQ;
  localparam logic [CNT_W-1:0] LO_BOUND =
    (EXP_PERIOD > TOL_COUNT) ? CNT_W'(EXP_PERIOD - TOL_COUNT) : CNT_W'(1);
  localparam logic [CNT_W-1:0] HI_BOUND     = CNT_W'(EXP_PERIOD + TOL_COUNT);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_COUNT - 1);
  localparam int unsigned      MW           = $clog2(LOCK_CYCLES + 1);
  localparam logic [MW-1:0]    LOCK_M       = MW'(LOCK_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_MEASURE, ST_LOCKED} state_e;

  logic sync1_q, sync2_q, prev_q;
  logic level, rise;

  // NOTE: every register below is updated with <= so all flops sample the
  // same pre-edge values; blocking assignments here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= wave_in;
      sync2_q <= sync1_q;
      prev_q  <= level;
    end
  end

`ifdef GLITCH_FILTER_EN
  localparam int unsigned FILTER_LEN = 8;
  localparam int unsigned FW         = $clog2(FILTER_LEN + 1);

  logic          filt_q;
  logic [FW-1:0] fcnt_q;

  // The filtered level follows the synchronizer only after it has disagreed
  // for FILTER_LEN consecutive clocks; any agreement restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else if (sync2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_q <= sync2_q;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end else begin
      fcnt_q <= '0;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  assign rise = level & ~prev_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MW-1:0]    mcnt_q, mcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             lock_q, lock_d;
  logic             nosig_q, nosig_d;
  logic             led_q;
  logic [CNT_W-1:0] period_meas;
  logic [MW-1:0]    mcnt_inc;
  logic             match;

  assign period_meas = cnt_q + 1'b1;
  assign match       = (period_meas >= LO_BOUND) && (period_meas <= HI_BOUND);
  assign mcnt_inc    = (mcnt_q == LOCK_M) ? mcnt_q : mcnt_q + 1'b1;

  // NOTE: every variable gets its hold value before the case so that no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcnt_d   = mcnt_q;
    period_d = period_q;
    valid_d  = 1'b0;
    lock_d   = lock_q;
    nosig_d  = nosig_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = ST_MEASURE;
          nosig_d = 1'b0;
        end
      end
      ST_MEASURE, ST_LOCKED: begin
        if (rise) begin
          // A rise on the timeout cycle is still a valid (long) period.
          period_d = period_meas;
          valid_d  = 1'b1;
          cnt_d    = '0;
          if (match) begin
            mcnt_d = mcnt_inc;
            if (mcnt_inc == LOCK_M) begin
              state_d = ST_LOCKED;
              lock_d  = 1'b1;
            end
          end else begin
            mcnt_d  = '0;
            state_d = ST_MEASURE;
            lock_d  = 1'b0;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_IDLE;
          nosig_d = 1'b1;
          lock_d  = 1'b0;
          mcnt_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcnt_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      lock_q   <= 1'b0;
      nosig_q  <= 1'b1;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcnt_q   <= mcnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      lock_q   <= lock_d;
      nosig_q  <= nosig_d;
      led_q    <= lock_d;
    end
  end

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign tone_lock    = lock_q;
  assign no_signal    = nosig_q;
  assign led          = led_q;

endmodule

// File: tb/tb_square_wave_period_detector.sv
// Scoreboard bench: an event-level model predicts start / period / timeout events,
// a monitor pops and compares them whenever the detector reports something.
module tb_square_wave_period_detector;

  localparam int unsigned CLK_FREQ  = 1000;
  localparam int unsigned WAVE_FREQ = 10;
  localparam int unsigned TOL       = 5;
  localparam int unsigned LOCKN     = 4;
  localparam int unsigned TMO       = 200;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned EXP       = CLK_FREQ / WAVE_FREQ;
`ifdef GLITCH_FILTER_EN
  localparam int unsigned FILTER_LEN = 8;
`endif

  logic             clk, rst_n, wave_in;
  logic [CNT_W-1:0] period_out;
  logic             period_valid, tone_lock, no_signal, led;

  square_wave_period_detector #(
    .CLK_FREQ(CLK_FREQ), .WAVE_FREQ(WAVE_FREQ), .TOL_COUNT(TOL),
    .LOCK_CYCLES(LOCKN), .TIMEOUT_COUNT(TMO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wave_in(wave_in),
    .period_out(period_out), .period_valid(period_valid),
    .tone_lock(tone_lock), .no_signal(no_signal), .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {EV_START, EV_PERIOD, EV_TIMEOUT} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    int unsigned period;
    bit          lock;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model (sample-level events) ----------------
  bit          m_rst = 1'b1;
  bit          m_prev, m_active, m_lock;
  int unsigned m_elapsed, m_matches, m_last_period;
`ifdef GLITCH_FILTER_EN
  bit          m_flt;
  int unsigned m_run;
`endif

  task automatic model_clear();
    m_prev = 0; m_active = 0; m_lock = 0;
    m_elapsed = 0; m_matches = 0; m_last_period = 0;
`ifdef GLITCH_FILTER_EN
    m_flt = 0; m_run = 0;
`endif
  endtask

  task automatic model_step(input bit v);
    bit  lvl, rise;
    ev_t e;
    if (m_rst) return;
`ifdef GLITCH_FILTER_EN
    if (v != m_flt) begin
      m_run++;
      if (m_run == FILTER_LEN) begin
        m_flt = v;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    lvl = m_flt;
`else
    lvl = v;
`endif
    rise   = lvl && !m_prev;
    m_prev = lvl;
    if (!m_active) begin
      if (rise) begin
        m_active  = 1;
        m_elapsed = 0;
        e.kind = EV_START; e.period = m_last_period; e.lock = 0;
        exp_q.push_back(e);
      end
    end else begin
      m_elapsed++;
      if (rise) begin
        if (m_elapsed >= EXP - TOL && m_elapsed <= EXP + TOL)
          m_matches = (m_matches < LOCKN) ? m_matches + 1 : LOCKN;
        else
          m_matches = 0;
        m_lock        = (m_matches == LOCKN);
        m_last_period = m_elapsed;
        m_elapsed     = 0;
        e.kind = EV_PERIOD; e.period = m_last_period; e.lock = m_lock;
        exp_q.push_back(e);
      end else if (m_elapsed == TMO) begin
        m_active  = 0;
        m_lock    = 0;
        m_matches = 0;
        e.kind = EV_TIMEOUT; e.period = m_last_period; e.lock = 0;
        exp_q.push_back(e);
      end
    end
  endtask

  // ---------------- monitor ----------------
  longint cyc = 0;
  longint last_rise = 0;
  bit     prev_nosig = 1'b1;

  task automatic take(input ev_kind_e k);
    ev_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event: got %s, expected no event (t=%0t)", k.name(), $time);
      return;
    end
    e = exp_q.pop_front();
    check($sformatf("event_kind_%s", e.kind.name()), int'(k), int'(e.kind));
    case (k)
      EV_START: begin
        check("start_no_valid", period_valid, 0);
        check("start_lock", tone_lock, 0);
        last_rise = cyc;
      end
      EV_PERIOD: begin
        check("period_out", period_out, e.period);
        check("period_gap", cyc - last_rise, e.period);
        check("period_lock", tone_lock, e.lock);
        check("period_led", led, e.lock);
        check("period_no_signal", no_signal, 0);
        last_rise = cyc;
      end
      default: begin
        check("timeout_gap", cyc - last_rise, TMO);
        check("timeout_lock", tone_lock, 0);
        check("timeout_led", led, 0);
        check("timeout_period_hold", period_out, e.period);
      end
    endcase
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_nosig = 1'b1;
    end else begin
      if (prev_nosig && !no_signal) take(EV_START);
      if (period_valid)             take(EV_PERIOD);
      if (!prev_nosig && no_signal) take(EV_TIMEOUT);
      prev_nosig = no_signal;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input bit v);
    @(negedge clk);
    wave_in = v;
    model_step(v);
  endtask

  task automatic hold(input bit v, input int n);
    repeat (n) tick(v);
  endtask

  task automatic square(input int p, input int hi);
    hold(1'b1, hi);
    hold(1'b0, p - hi);
  endtask

  task automatic do_reset(input bit v);
    @(negedge clk);
    rst_n   = 1'b0;
    wave_in = v;
    m_rst   = 1'b1;
    #1;
    check("rst_period_out", period_out, 0);
    check("rst_period_valid", period_valid, 0);
    check("rst_tone_lock", tone_lock, 0);
    check("rst_no_signal", no_signal, 1);
    check("rst_led", led, 0);
    check("drained_before_reset", exp_q.size(), 0);
    exp_q.delete();
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_rst = 1'b0;
    model_step(v);
  endtask

  initial begin
    int p, hi;
    rst_n   = 1'b0;
    wave_in = 1'b0;
    do_reset(1'b0);

    // Static input: nothing should happen.
    hold(1'b0, 500);
    check("static_no_signal", no_signal, 1);
    check("static_lock", tone_lock, 0);
    check("static_period_out", period_out, 0);

    // Nominal tone: lock on the fourth period, then an off-frequency period.
    repeat (6) square(EXP, EXP / 2);
    square(EXP + 10, 50);
    repeat (5) square(EXP, 50);

    // Tolerance boundaries.
    square(EXP - TOL, 40);
    square(EXP + TOL, 40);
    square(EXP - TOL - 1, 40);
    repeat (4) square(EXP, 50);
    square(EXP + TOL + 1, 40);

    // Loss of signal after lock.
    repeat (5) square(EXP, 50);
    hold(1'b1, 50);
    hold(1'b0, 350);

    // Rise exactly on the timeout cycle.
    square(TMO, 50);
    hold(1'b1, 20);
    hold(1'b0, 400);

    // Short glitches inside a locked wave.
    repeat (5) square(EXP, 50);
    repeat (4) begin
      hold(1'b1, 50); hold(1'b0, 20); hold(1'b1, 3); hold(1'b0, 27);
    end
    hold(1'b0, 300);

    // Randomized periods and duty cycles.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0) p = $urandom_range(EXP - TOL - 2, EXP + TOL + 2);
      else                           p = $urandom_range(2, 250);
      hi = $urandom_range(1, p - 1);
      square(p, hi);
    end
    hold(1'b0, 300);

    // Reset in the middle of a measurement, released with wave_in high.
    repeat (3) square(EXP, 50);
    hold(1'b1, 30);
    do_reset(1'b1);
    hold(1'b1, 49);
    hold(1'b0, 50);
    repeat (5) square(EXP, 50);
    hold(1'b0, 300);

    hold(1'b0, 10);
    check("queue_empty_at_end", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
